cardinal_input_port: RTL and testbench

Router-side input port directly downstream of the cardinal NIC output channel, or of a neighbouring router output channel. Accepts 64-bit packets over the si/ri/di handshake into two one-entry virtual-channel slots (VC0/VC1) selected by the packet VC bit. Precomputes an XY route at write time and presents a one-hot switch request with the hop count already decremented. Follows the polarity discipline: a VC moves on the link in the opposite-polarity cycle and through the switch in the same-polarity cycle.

---
 rtl/cardinal_pkg.sv | 26 ++
 rtl/cardinal_input_port_if.sv | 14 +
 rtl/cardinal_vc_slot.sv | 50 +++++
 rtl/cardinal_input_port.sv | 45 ++++
 tb/tb_cardinal_input_port.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal router input port: packet field positions,
// route encodings and the XY route selection function.
package cardinal_pkg;

  localparam int PAC_WIDTH = 64;

  localparam int VC_BIT = 0;
  localparam int DX_BIT = 1;
  localparam int DY_BIT = 2;
  localparam int HX_MSB = 8;
  localparam int HX_LSB = 15;
  localparam int HY_MSB = 16;
  localparam int HY_LSB = 23;

  localparam logic [0:2] ROUTE_X  = 3'b100;
  localparam logic [0:2] ROUTE_Y  = 3'b010;
  localparam logic [0:2] ROUTE_PE = 3'b001;

  // X is exhausted before Y; a packet with no hops left is for the local PE.
  function automatic logic [0:2] route_of(input logic [0:PAC_WIDTH-1] pkt);
    if (pkt[HX_MSB:HX_LSB] != 8'd0) return ROUTE_X;
    if (pkt[HY_MSB:HY_LSB] != 8'd0) return ROUTE_Y;
    return ROUTE_PE;
  endfunction

endpackage

// File: rtl/cardinal_input_port_if.sv
// Link-side (si/ri/di) and switch-side (req/gnt/do) signals of the input port.
interface cardinal_input_port_if;
  import cardinal_pkg::*;

  logic                 in_si;
  logic                 in_ri;
  logic [0:PAC_WIDTH-1] in_di;
  logic [0:2]           sw_req;
  logic                 sw_gnt;
  logic [0:PAC_WIDTH-1] sw_do;

  modport master (output in_si, in_di, sw_gnt, input in_ri, sw_req, sw_do);
  modport slave  (input in_si, in_di, sw_gnt, output in_ri, sw_req, sw_do);
endinterface

// File: rtl/cardinal_vc_slot.sv
// One-entry virtual-channel slot: packet register, full flag, precomputed route
// and the hop-decremented view presented to the crossbar.
module cardinal_vc_slot
  import cardinal_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [0:PAC_WIDTH-1] wr_data,
  input  logic                 clr,
  output logic                 full,
  output logic [0:2]           req,
  output logic [0:PAC_WIDTH-1] rd_data
);

  logic                 full_q;
  logic [0:2]           route_q;
  logic [0:PAC_WIDTH-1] data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      full_q  <= 1'b0;
      route_q <= 3'b000;
      data_q  <= '0;
    end else if (wr_en) begin
      full_q  <= 1'b1;
      route_q <= route_of(wr_data);
      data_q  <= wr_data;
    end else if (clr) begin
      full_q  <= 1'b0;
    end
  end

  // The route only picks a dimension whose count is nonzero, so no underflow.
  always_comb begin
    rd_data = '0;
    req     = 3'b000;
    if (full_q) begin
      req     = route_q;
      rd_data = data_q;
      if (route_q == ROUTE_X)
        rd_data[HX_MSB:HX_LSB] = data_q[HX_MSB:HX_LSB] - 8'd1;
      else if (route_q == ROUTE_Y)
        rd_data[HY_MSB:HY_LSB] = data_q[HY_MSB:HY_LSB] - 8'd1;
    end
  end

  assign full = full_q;

endmodule

// File: rtl/cardinal_input_port.sv
// Router input port: two VC slots, written on the link in the opposite-polarity
// cycle and read through the switch in the same-polarity cycle.
module cardinal_input_port
  import cardinal_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  cardinal_input_port_if.slave  port
);

  logic                 wv;
  logic                 rv;
  logic                 wr_ok;
  logic [1:0]           full;
  logic [0:2]           req  [2];
  logic [0:PAC_WIDTH-1] rdat [2];

  assign wv = ~polarity;
  assign rv = polarity;

  assign port.in_ri = ~full[wv];
  assign wr_ok      = port.in_si & port.in_ri & (port.in_di[VC_BIT] == wv);

  // wv and rv always differ, so a write and a grant never hit the same slot.
  for (genvar v = 0; v < 2; v++) begin : g_slot
    cardinal_vc_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_ok & (wv == 1'(v))),
      .wr_data (port.in_di),
      .clr     (port.sw_gnt & full[v] & (rv == 1'(v))),
      .full    (full[v]),
      .req     (req[v]),
      .rd_data (rdat[v])
    );
  end

  assign port.sw_req = req[rv];
  assign port.sw_do  = rdat[rv];

  a_vc_matches_polarity : assert property (@(posedge clk) disable iff (!reset)
    !(port.in_si && port.in_ri && (port.in_di[VC_BIT] != wv)));

endmodule

// File: tb/tb_cardinal_input_port.sv
// Directed bench for cardinal_input_port; polarity is driven explicitly per cycle.
module tb_cardinal_input_port;
  import cardinal_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic polarity;
  int   tests = 0;
  int   fails = 0;

  cardinal_input_port_if bus ();

  cardinal_input_port dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .port     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [0:PAC_WIDTH-1] mk(input logic vc, input logic dx, input logic dy,
                                               input logic [7:0] hx, input logic [7:0] hy,
                                               input logic [39:0] pl);
    return {vc, dx, dy, 5'b00000, hx, hy, pl};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.in_si = 1'b1; bus.sw_gnt = 1'b0;
    polarity = 1'b1; bus.in_di = mk(1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 40'h1);
    step();
    polarity = 1'b0; bus.in_di = mk(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 40'h2);
    step();
    bus.in_si = 1'b0; reset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      polarity = p[0];
      #1;
      tests++; if (bus.in_ri !== 1'b1) begin fails++; $display("FAIL reset_ri pol=%0d got %b exp 1", p, bus.in_ri); end
      tests++; if (bus.sw_req !== 3'b000) begin fails++; $display("FAIL reset_req pol=%0d got %b exp 000", p, bus.sw_req); end
      tests++; if (bus.sw_do !== '0) begin fails++; $display("FAIL reset_do pol=%0d got %h exp 0", p, bus.sw_do); end
    end
  endtask

  task automatic test_x_route();
    polarity = 1'b1; bus.in_si = 1'b1;
    bus.in_di = mk(1'b0, 1'b0, 1'b0, 8'd3, 8'd2, 40'h12_3456_789A);
    #1;
    tests++; if (bus.in_ri !== 1'b1) begin fails++; $display("FAIL x_ri got %b exp 1", bus.in_ri); end
    step();
    bus.in_si = 1'b0; polarity = 1'b0;
    #1;
    tests++; if (bus.sw_req !== 3'b100) begin fails++; $display("FAIL x_req got %b exp 100", bus.sw_req); end
    tests++; if (bus.sw_do !== mk(1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 40'h12_3456_789A))
      begin fails++; $display("FAIL x_do got %h exp %h", bus.sw_do, mk(1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 40'h12_3456_789A)); end
    bus.sw_gnt = 1'b1;
    step();
    bus.sw_gnt = 1'b0;
    #1;
    tests++; if (bus.sw_req !== 3'b000) begin fails++; $display("FAIL x_gnt_req got %b exp 000", bus.sw_req); end
    tests++; if (bus.sw_do !== '0) begin fails++; $display("FAIL x_gnt_do got %h exp 0", bus.sw_do); end
    polarity = 1'b1;
    #1;
    tests++; if (bus.in_ri !== 1'b1) begin fails++; $display("FAIL x_gnt_ri got %b exp 1", bus.in_ri); end
  endtask

  task automatic test_y_pe();
    logic [0:PAC_WIDTH-1] pe;
    polarity = 1'b0; bus.in_si = 1'b1;
    bus.in_di = mk(1'b1, 1'b1, 1'b1, 8'd0, 8'd1, 40'hAB_CDEF_0123);
    step();
    bus.in_si = 1'b0; polarity = 1'b1;
    #1;
    tests++; if (bus.sw_req !== 3'b010) begin fails++; $display("FAIL y_req got %b exp 010", bus.sw_req); end
    tests++; if (bus.sw_do !== mk(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 40'hAB_CDEF_0123))
      begin fails++; $display("FAIL y_do got %h exp %h", bus.sw_do, mk(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 40'hAB_CDEF_0123)); end
    bus.sw_gnt = 1'b1;
    step();
    bus.sw_gnt = 1'b0;
    pe = mk(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 40'h00_0000_CAFE);
    pe[3:7] = 5'b10110;
    polarity = 1'b0; bus.in_si = 1'b1; bus.in_di = pe;
    step();
    bus.in_si = 1'b0; polarity = 1'b1;
    #1;
    tests++; if (bus.sw_req !== 3'b001) begin fails++; $display("FAIL pe_req got %b exp 001", bus.sw_req); end
    tests++; if (bus.sw_do !== pe) begin fails++; $display("FAIL pe_do got %h exp %h", bus.sw_do, pe); end
    bus.sw_gnt = 1'b1;
    step();
    bus.sw_gnt = 1'b0;
    #1;
    tests++; if (bus.sw_req !== 3'b000) begin fails++; $display("FAIL pe_gnt_req got %b exp 000", bus.sw_req); end
  endtask

  task automatic test_backpressure();
    polarity = 1'b1; bus.in_si = 1'b1;
    bus.in_di = mk(1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 40'h11_1111_1111);
    step();
    bus.in_si = 1'b0; polarity = 1'b0;
    step();
    polarity = 1'b1; bus.in_si = 1'b1;
    bus.in_di = mk(1'b0, 1'b0, 1'b0, 8'd5, 8'd5, 40'h22_2222_2222);
    #1;
    tests++; if (bus.in_ri !== 1'b0) begin fails++; $display("FAIL bp_ri got %b exp 0", bus.in_ri); end
    step();
    bus.in_si = 1'b0; polarity = 1'b0;
    #1;
    tests++; if (bus.sw_req !== 3'b100) begin fails++; $display("FAIL bp_req got %b exp 100", bus.sw_req); end
    tests++; if (bus.sw_do !== mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 40'h11_1111_1111))
      begin fails++; $display("FAIL bp_do got %h exp %h", bus.sw_do, mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 40'h11_1111_1111)); end
    bus.sw_gnt = 1'b1;
    step();
    bus.sw_gnt = 1'b0; polarity = 1'b1;
    #1;
    tests++; if (bus.in_ri !== 1'b1) begin fails++; $display("FAIL bp_release_ri got %b exp 1", bus.in_ri); end
  endtask

  task automatic test_concurrency();
    polarity = 1'b0; bus.in_si = 1'b1;
    bus.in_di = mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 40'h33_3333_3333);
    step();
    polarity = 1'b1; bus.in_si = 1'b1; bus.sw_gnt = 1'b1;
    bus.in_di = mk(1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 40'h44_4444_4444);
    #1;
    tests++; if (bus.sw_req !== 3'b010) begin fails++; $display("FAIL cc_req1 got %b exp 010", bus.sw_req); end
    tests++; if (bus.in_ri !== 1'b1) begin fails++; $display("FAIL cc_ri got %b exp 1", bus.in_ri); end
    step();
    bus.in_si = 1'b0; bus.sw_gnt = 1'b0;
    #1;
    tests++; if (bus.sw_req !== 3'b000) begin fails++; $display("FAIL cc_slot1_req got %b exp 000", bus.sw_req); end
    tests++; if (bus.sw_do !== '0) begin fails++; $display("FAIL cc_slot1_do got %h exp 0", bus.sw_do); end
    polarity = 1'b0;
    #1;
    tests++; if (bus.sw_req !== 3'b100) begin fails++; $display("FAIL cc_slot0_req got %b exp 100", bus.sw_req); end
    tests++; if (bus.sw_do !== mk(1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 40'h44_4444_4444))
      begin fails++; $display("FAIL cc_slot0_do got %h exp %h", bus.sw_do, mk(1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 40'h44_4444_4444)); end
    bus.sw_gnt = 1'b1;
    step();
    bus.sw_gnt = 1'b0;
  endtask

  task automatic test_mid_reset();
    polarity = 1'b0; bus.in_si = 1'b1;
    bus.in_di = mk(1'b1, 1'b0, 1'b1, 8'd0, 8'd7, 40'h55_5555_5555);
    step();
    polarity = 1'b1;
    bus.in_di = mk(1'b0, 1'b0, 1'b0, 8'd9, 8'd0, 40'h66_6666_6666);
    #1;
    tests++; if (bus.sw_req !== 3'b010) begin fails++; $display("FAIL mr_pre_req1 got %b exp 010", bus.sw_req); end
    step();
    bus.in_si = 1'b0; polarity = 1'b0;
    #1;
    tests++; if (bus.sw_req !== 3'b100) begin fails++; $display("FAIL mr_pre_req0 got %b exp 100", bus.sw_req); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      polarity = p[0];
      #1;
      tests++; if (bus.sw_req !== 3'b000) begin fails++; $display("FAIL mr_req pol=%0d got %b exp 000", p, bus.sw_req); end
      tests++; if (bus.sw_do !== '0) begin fails++; $display("FAIL mr_do pol=%0d got %h exp 0", p, bus.sw_do); end
      tests++; if (bus.in_ri !== 1'b1) begin fails++; $display("FAIL mr_ri pol=%0d got %b exp 1", p, bus.in_ri); end
    end
  endtask

  initial begin
    reset = 1'b0; polarity = 1'b0;
    bus.in_si = 1'b0; bus.sw_gnt = 1'b0; bus.in_di = '0;
    test_reset();
    test_x_route();
    test_y_pe();
    test_backpressure();
    test_concurrency();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
